// File: rtl/serial_io_pkg.sv
// Shared types and helpers for the serial peripheral bus scheduler:
// FSM states, job indices and the round-robin ring helpers.
package serial_io_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef logic [1:0] job_t;

   localparam job_t JOB_LED = 2'd0;
   localparam job_t JOB_DIP = 2'd1;
   localparam job_t JOB_SEG = 2'd2;

   // Ring order LED -> DIP -> SEG -> LED
   function automatic job_t rr_next(input job_t job);
      job_t nxt;
      case (job)
         JOB_LED: nxt = JOB_DIP;
         JOB_DIP: nxt = JOB_SEG;
         default: nxt = JOB_LED;
      endcase
      return nxt;
   endfunction

   function automatic job_t rr_pick(input logic [2:0] pend, input job_t ptr);
      job_t c0;
      job_t c1;
      job_t c2;
      job_t pick;
      c0 = ptr;
      c1 = rr_next(c0);
      c2 = rr_next(c1);
      if (pend[c0]) begin
         pick = c0;
      end else if (pend[c1]) begin
         pick = c1;
      end else begin
         pick = c2;
      end
      return pick;
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/psclk_gen.sv
// Shift-clock timebase: counts half-periods while enabled, restarts in the low
// phase on every enable, and drives PSCLK high only when allowed to.
module psclk_gen
   import serial_io_pkg::*;
#(
   parameter int CLK_DIV = 5
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en_d,
   input  logic i_drive_d,
   output logic o_psclk,
   output logic o_rise,
   output logic o_last
);

   localparam int CW = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          half_q;
   logic          half_d;
   logic          en_q;
   logic          psclk_q;
   logic          psclk_d;

   // Next half-period position and registered shift clock level
   always_comb begin
      cnt_d  = '0;
      half_d = 1'b0;
      if (!i_en_d) begin
         cnt_d  = '0;
         half_d = 1'b0;
      end else if (!en_q) begin
         cnt_d  = '0;
         half_d = 1'b0;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d  = '0;
         half_d = ~half_q;
      end else begin
         cnt_d  = cnt_q + CW'(1);
         half_d = half_q;
      end
      psclk_d = half_d & i_drive_d;
   end

   // Timebase registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q   <= '0;
         half_q  <= 1'b0;
         en_q    <= 1'b0;
         psclk_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         half_q  <= half_d;
         en_q    <= i_en_d;
         psclk_q <= psclk_d;
      end
   end

   assign o_psclk = psclk_q;
   assign o_rise  = en_q & half_q & (cnt_q == '0);
   assign o_last  = en_q & half_q & (cnt_q == CNT_MAX);

endmodule

// File: rtl/serial_io_scheduler.sv
// Round-robin scheduler for the shared LED / DIP / 7-seg shift bus: captures
// requests, grants one job at a time and runs it on the common PSCLK.
module serial_io_scheduler
   import serial_io_pkg::*;
#(
   parameter int CLK_DIV = 5,
   parameter int LED_W   = 8,
   parameter int DIP_W   = 8,
   parameter int SEG_W   = 16
) (
   input  logic             i_CLK,
   input  logic             i_SYS_RESET,
   input  logic             i_LED_wr,
   input  logic [LED_W-1:0] i_LED,
   input  logic             i_SEG_wr,
   input  logic [SEG_W-1:0] i_SEG,
   input  logic             i_DIP_rd,
   output logic [DIP_W-1:0] o_DIP,
   output logic             o_DIP_valid,
   output logic             o_busy,
   output logic             o_PSCLK,
   output logic             o_LEDData,
   output logic             o_LEDLatch,
   output logic             o_SEGData,
   output logic             o_SEGLatch,
   output logic             o_DIPLatch,
   input  logic             i_DIPData
);

   localparam int MAX_W = (LED_W > DIP_W) ? ((LED_W > SEG_W) ? LED_W : SEG_W)
                                          : ((DIP_W > SEG_W) ? DIP_W : SEG_W);
   localparam int BW = cnt_width(MAX_W);

   state_t           state_q, state_d;
   job_t             job_q, job_d;
   job_t             ptr_q, ptr_d;
   job_t             gnt;
   logic [2:0]       pend_q, pend_d;
   logic [LED_W-1:0] led_shadow_q, led_shadow_d;
   logic [SEG_W-1:0] seg_shadow_q, seg_shadow_d;
   logic [MAX_W-1:0] sh_q, sh_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             data_q, data_d;
   logic [DIP_W-1:0] dip_sh_q, dip_sh_d;
   logic [DIP_W-1:0] dip_q, dip_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             led_data_q, led_data_d;
   logic             seg_data_q, seg_data_d;
   logic             led_latch_q, led_latch_d;
   logic             seg_latch_q, seg_latch_d;
   logic             dip_latch_q, dip_latch_d;
   logic             gen_en_d;
   logic             gen_drive_d;
   logic             psclk_rise;
   logic             psclk_last;

   psclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_psclk_gen (
      .i_clk     (i_CLK),
      .i_rst     (i_SYS_RESET),
      .i_en_d    (gen_en_d),
      .i_drive_d (gen_drive_d),
      .o_psclk   (o_PSCLK),
      .o_rise    (psclk_rise),
      .o_last    (psclk_last)
   );

   // Request capture, arbitration, job sequencing and next output values
   always_comb begin
      state_d  = state_q;
      job_d    = job_q;
      ptr_d    = ptr_q;
      pend_d   = pend_q;
      sh_d     = sh_q;
      bit_d    = bit_q;
      data_d   = data_q;
      dip_sh_d = dip_sh_q;
      dip_d    = dip_q;
      gnt      = rr_pick(pend_q, ptr_q);

      if (i_LED_wr) begin
         led_shadow_d = i_LED;
      end else begin
         led_shadow_d = led_shadow_q;
      end
      if (i_SEG_wr) begin
         seg_shadow_d = i_SEG;
      end else begin
         seg_shadow_d = seg_shadow_q;
      end

      case (state_q)
         IDLE: begin
            if (|pend_q) begin
               job_d       = gnt;
               ptr_d       = rr_next(gnt);
               pend_d[gnt] = 1'b0;
               case (gnt)
                  JOB_DIP: begin
                     state_d = LOAD;
                     bit_d   = BW'(DIP_W - 1);
                     data_d  = 1'b0;
                  end
                  JOB_SEG: begin
                     state_d = SHIFT;
                     sh_d    = MAX_W'(seg_shadow_q);
                     bit_d   = BW'(SEG_W - 1);
                     data_d  = seg_shadow_q[SEG_W-1];
                  end
                  default: begin
                     state_d = SHIFT;
                     sh_d    = MAX_W'(led_shadow_q);
                     bit_d   = BW'(LED_W - 1);
                     data_d  = led_shadow_q[LED_W-1];
                  end
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (psclk_last) begin
               state_d = SHIFT;
            end else begin
               state_d = LOAD;
            end
         end
         SHIFT: begin
            if ((job_q == JOB_DIP) && psclk_rise) begin
               dip_sh_d = {dip_sh_q[DIP_W-2:0], i_DIPData};
            end else begin
               dip_sh_d = dip_sh_q;
            end
            // Next bit is presented at the start of the following low phase
            if (psclk_last) begin
               if (bit_q == '0) begin
                  data_d = 1'b0;
                  if (job_q == JOB_DIP) begin
                     state_d = DONE;
                     dip_d   = dip_sh_d;
                  end else begin
                     state_d = LATCH;
                  end
               end else begin
                  bit_d  = bit_q - BW'(1);
                  data_d = sh_q[bit_q - BW'(1)];
               end
            end else begin
               state_d = SHIFT;
            end
         end
         LATCH: begin
            if (psclk_last) begin
               state_d = IDLE;
            end else begin
               state_d = LATCH;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A request arriving on its own grant cycle re-arms the job
      pend_d = pend_d | {i_SEG_wr, i_DIP_rd, i_LED_wr};

      gen_en_d    = (state_d == LOAD) || (state_d == SHIFT) || (state_d == LATCH);
      gen_drive_d = (state_d == SHIFT);
      busy_d      = (state_d != IDLE);
      valid_d     = (state_d == DONE);
      dip_latch_d = (state_d == LOAD);
      led_latch_d = (state_d == LATCH) && (job_d == JOB_LED);
      seg_latch_d = (state_d == LATCH) && (job_d == JOB_SEG);
      led_data_d  = (state_d == SHIFT) && (job_d == JOB_LED) && data_d;
      seg_data_d  = (state_d == SHIFT) && (job_d == JOB_SEG) && data_d;
   end

   // Scheduler state and registered pin outputs
   always_ff @(posedge i_CLK) begin
      if (i_SYS_RESET) begin
         state_q      <= IDLE;
         job_q        <= JOB_LED;
         ptr_q        <= JOB_LED;
         pend_q       <= 3'b000;
         led_shadow_q <= '0;
         seg_shadow_q <= '0;
         sh_q         <= '0;
         bit_q        <= '0;
         data_q       <= 1'b0;
         dip_sh_q     <= '0;
         dip_q        <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         led_data_q   <= 1'b0;
         seg_data_q   <= 1'b0;
         led_latch_q  <= 1'b0;
         seg_latch_q  <= 1'b0;
         dip_latch_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         job_q        <= job_d;
         ptr_q        <= ptr_d;
         pend_q       <= pend_d;
         led_shadow_q <= led_shadow_d;
         seg_shadow_q <= seg_shadow_d;
         sh_q         <= sh_d;
         bit_q        <= bit_d;
         data_q       <= data_d;
         dip_sh_q     <= dip_sh_d;
         dip_q        <= dip_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         led_data_q   <= led_data_d;
         seg_data_q   <= seg_data_d;
         led_latch_q  <= led_latch_d;
         seg_latch_q  <= seg_latch_d;
         dip_latch_q  <= dip_latch_d;
      end
   end

   assign o_DIP       = dip_q;
   assign o_DIP_valid = valid_q;
   assign o_busy      = busy_q;
   assign o_LEDData   = led_data_q;
   assign o_LEDLatch  = led_latch_q;
   assign o_SEGData   = seg_data_q;
   assign o_SEGLatch  = seg_latch_q;
   assign o_DIPLatch  = dip_latch_q;

endmodule

// File: tb/tb_serial_io_scheduler.sv
// Directed bench for serial_io_scheduler at CLK_DIV=2 with a DIP-switch
// shift-register model and a negedge monitor that tallies bus activity.
module tb_serial_io_scheduler;

   localparam int CLK_DIV = 2;
   localparam int LED_W   = 8;
   localparam int DIP_W   = 8;
   localparam int SEG_W   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_LED_wr;
   logic [LED_W-1:0] i_LED;
   logic             i_SEG_wr;
   logic [SEG_W-1:0] i_SEG;
   logic             i_DIP_rd;
   logic [DIP_W-1:0] o_DIP;
   logic             o_DIP_valid;
   logic             o_busy;
   logic             o_PSCLK;
   logic             o_LEDData;
   logic             o_LEDLatch;
   logic             o_SEGData;
   logic             o_SEGLatch;
   logic             o_DIPLatch;
   logic             i_DIPData;

   int total = 0;
   int bad   = 0;

   logic        mon_clr;
   int          rise_cnt, busy_cnt, led_latch_cnt, seg_latch_cnt, dip_latch_cnt;
   int          valid_cnt, led_hi_cnt, seg_hi_cnt, psclk_idle_hi;
   int          idle_run, gap_min, gap_max, order_cnt;
   logic [31:0] rx_led, rx_seg;
   logic [11:0] order;
   logic [7:0]  dip_at_valid;
   logic [7:0]  dip_sw = 8'h00;
   logic [7:0]  dip_model = 8'h00;
   logic        psclk_prev = 1'b0;
   logic        busy_prev = 1'b0;
   logic        seen_busy = 1'b0;
   logic        led_latch_prev = 1'b0;
   logic        seg_latch_prev = 1'b0;

   always #5 clk = ~clk;

   assign i_DIPData = dip_model[7];

   serial_io_scheduler #(
      .CLK_DIV (CLK_DIV),
      .LED_W   (LED_W),
      .DIP_W   (DIP_W),
      .SEG_W   (SEG_W)
   ) dut (
      .i_CLK       (clk),
      .i_SYS_RESET (rst),
      .i_LED_wr    (i_LED_wr),
      .i_LED       (i_LED),
      .i_SEG_wr    (i_SEG_wr),
      .i_SEG       (i_SEG),
      .i_DIP_rd    (i_DIP_rd),
      .o_DIP       (o_DIP),
      .o_DIP_valid (o_DIP_valid),
      .o_busy      (o_busy),
      .o_PSCLK     (o_PSCLK),
      .o_LEDData   (o_LEDData),
      .o_LEDLatch  (o_LEDLatch),
      .o_SEGData   (o_SEGData),
      .o_SEGLatch  (o_SEGLatch),
      .o_DIPLatch  (o_DIPLatch),
      .i_DIPData   (i_DIPData)
   );

   // Bus monitor plus DIP switch model (parallel load, shift on PSCLK fall)
   always @(negedge clk) begin
      if (mon_clr) begin
         rise_cnt <= 0; busy_cnt <= 0; led_latch_cnt <= 0; seg_latch_cnt <= 0;
         dip_latch_cnt <= 0; valid_cnt <= 0; led_hi_cnt <= 0; seg_hi_cnt <= 0;
         psclk_idle_hi <= 0; idle_run <= 0; gap_min <= 1000; gap_max <= 0;
         order_cnt <= 0; order <= 12'h000; rx_led <= 32'h0; rx_seg <= 32'h0;
         dip_at_valid <= 8'h00; seen_busy <= 1'b0;
      end else begin
         if (o_PSCLK && !psclk_prev) begin
            rise_cnt <= rise_cnt + 1;
            rx_led   <= {rx_led[30:0], o_LEDData};
            rx_seg   <= {rx_seg[30:0], o_SEGData};
         end
         if (o_busy) busy_cnt <= busy_cnt + 1;
         if (o_LEDLatch) led_latch_cnt <= led_latch_cnt + 1;
         if (o_SEGLatch) seg_latch_cnt <= seg_latch_cnt + 1;
         if (o_DIPLatch) dip_latch_cnt <= dip_latch_cnt + 1;
         if (o_LEDData) led_hi_cnt <= led_hi_cnt + 1;
         if (o_SEGData) seg_hi_cnt <= seg_hi_cnt + 1;
         if (!o_busy && o_PSCLK) psclk_idle_hi <= psclk_idle_hi + 1;
         if (o_LEDLatch && !led_latch_prev) begin
            order <= {order[9:0], 2'd1}; order_cnt <= order_cnt + 1;
         end else if (o_SEGLatch && !seg_latch_prev) begin
            order <= {order[9:0], 2'd3}; order_cnt <= order_cnt + 1;
         end else if (o_DIP_valid) begin
            order <= {order[9:0], 2'd2}; order_cnt <= order_cnt + 1;
         end
         if (o_DIP_valid) begin
            valid_cnt    <= valid_cnt + 1;
            dip_at_valid <= o_DIP;
         end
         if (o_busy) begin
            if (!busy_prev && seen_busy) begin
               if (idle_run < gap_min) gap_min <= idle_run;
               if (idle_run > gap_max) gap_max <= idle_run;
            end
            seen_busy <= 1'b1;
            idle_run  <= 0;
         end else begin
            idle_run <= idle_run + 1;
         end
      end
      if (o_DIPLatch) begin
         dip_model <= dip_sw;
      end else if (psclk_prev && !o_PSCLK) begin
         dip_model <= {dip_model[6:0], 1'b0};
      end
      psclk_prev     <= o_PSCLK;
      busy_prev      <= o_busy;
      led_latch_prev <= o_LEDLatch;
      seg_latch_prev <= o_SEGLatch;
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      mon_clr = 1'b1;
      @(negedge clk);
      #1;
      mon_clr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; mon_clr = 1'b1;
      i_LED_wr = 1'b0; i_LED = 8'h00; i_SEG_wr = 1'b0; i_SEG = 16'h0000; i_DIP_rd = 1'b0;
      cycles(3);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_psclk", {31'd0, o_PSCLK}, 32'd0);
      check("rst_dip", {24'd0, o_DIP}, 32'd0);
      check("rst_valid", {31'd0, o_DIP_valid}, 32'd0);
      check("rst_pins", {27'd0, o_LEDData, o_LEDLatch, o_SEGData, o_SEGLatch, o_DIPLatch}, 32'd0);
      rst = 1'b0;
      cycles(2);

      // LED write 8'hA5
      clr();
      i_LED = 8'hA5; i_LED_wr = 1'b1;
      cycles(1);
      i_LED_wr = 1'b0;
      check("led_lat_capture", {31'd0, o_busy}, 32'd0);
      cycles(1);
      check("led_lat_busy", {31'd0, o_busy}, 32'd1);
      check("led_lat_psclk", {31'd0, o_PSCLK}, 32'd0);
      cycles(60);
      check("led_rises", rise_cnt, 32'd8);
      check("led_bits", {24'd0, rx_led[7:0]}, 32'h0000_00A5);
      check("led_latch_len", led_latch_cnt, 32'd4);
      check("led_busy_len", busy_cnt, 32'd36);
      check("led_seg_quiet", seg_hi_cnt, 32'd0);
      check("led_idle_after", {31'd0, o_busy}, 32'd0);

      // DIP read of 8'h3C
      dip_sw = 8'h3C;
      clr();
      i_DIP_rd = 1'b1;
      cycles(1);
      i_DIP_rd = 1'b0;
      cycles(60);
      check("dip_latch_len", dip_latch_cnt, 32'd4);
      check("dip_rises", rise_cnt, 32'd8);
      check("dip_value", {24'd0, o_DIP}, 32'h0000_003C);
      check("dip_at_valid", {24'd0, dip_at_valid}, 32'h0000_003C);
      check("dip_valid_cnt", valid_cnt, 32'd1);
      check("dip_busy_len", busy_cnt, 32'd37);
      check("dip_data_quiet", led_hi_cnt + seg_hi_cnt, 32'd0);

      // Reset to bring the pointer back to LED, then all three at once
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(1);
      dip_sw = 8'h5A;
      clr();
      i_LED = 8'h81; i_SEG = 16'h1234;
      i_LED_wr = 1'b1; i_SEG_wr = 1'b1; i_DIP_rd = 1'b1;
      cycles(1);
      i_LED_wr = 1'b0; i_SEG_wr = 1'b0; i_DIP_rd = 1'b0;
      cycles(170);
      check("arb_jobs", order_cnt, 32'd3);
      check("arb_order", {26'd0, order[5:0]}, {26'd0, 2'd1, 2'd2, 2'd3});
      check("arb_gap_min", gap_min, 32'd1);
      check("arb_gap_max", gap_max, 32'd1);
      check("arb_psclk_idle", psclk_idle_hi, 32'd0);
      check("arb_busy_len", busy_cnt, 32'd141);
      check("arb_rises", rise_cnt, 32'd32);
      check("arb_led_bits", rx_led, 32'h8100_0000);
      check("arb_seg_bits", {16'd0, rx_seg[15:0]}, 32'h0000_1234);
      check("arb_dip_value", {24'd0, o_DIP}, 32'h0000_005A);

      // Pointer back at LED: LED wins over SEG
      clr();
      i_LED = 8'h3C; i_SEG = 16'h00FF;
      i_LED_wr = 1'b1; i_SEG_wr = 1'b1;
      cycles(1);
      i_LED_wr = 1'b0; i_SEG_wr = 1'b0;
      cycles(130);
      check("ptr_jobs", order_cnt, 32'd2);
      check("ptr_order", {28'd0, order[3:0]}, {28'd0, 2'd1, 2'd3});
      check("ptr_led_bits", {8'd0, rx_led[23:0]}, 32'h003C_0000);
      check("ptr_seg_bits", {16'd0, rx_seg[15:0]}, 32'h0000_00FF);

      // Re-request while the first LED job is shifting
      clr();
      i_LED = 8'hF0; i_LED_wr = 1'b1;
      cycles(1);
      i_LED_wr = 1'b0;
      cycles(10);
      i_LED = 8'h0F; i_LED_wr = 1'b1;
      cycles(1);
      i_LED_wr = 1'b0;
      cycles(100);
      check("rereq_bits", {16'd0, rx_led[15:0]}, 32'h0000_F00F);
      check("rereq_rises", rise_cnt, 32'd16);
      check("rereq_latch_len", led_latch_cnt, 32'd8);
      check("rereq_jobs", order_cnt, 32'd2);
      check("rereq_busy_len", busy_cnt, 32'd72);
      check("rereq_gap", gap_min, 32'd1);

      // Reset in the middle of a SEG shift with an LED job pending
      clr();
      i_SEG = 16'hFFFF; i_SEG_wr = 1'b1;
      cycles(1);
      i_SEG_wr = 1'b0;
      cycles(20);
      check("mid_busy", {31'd0, o_busy}, 32'd1);
      check("mid_segdata", {31'd0, o_SEGData}, 32'd1);
      i_LED = 8'h11; i_LED_wr = 1'b1;
      cycles(1);
      i_LED_wr = 1'b0;
      rst = 1'b1;
      cycles(1);
      check("abort_pins", {28'd0, o_PSCLK, o_SEGData, o_SEGLatch, o_busy}, 32'd0);
      rst = 1'b0;
      clr();
      cycles(80);
      check("abort_busy", busy_cnt, 32'd0);
      check("abort_latch", seg_latch_cnt + led_latch_cnt, 32'd0);
      check("abort_rises", rise_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
